hex_display_scroller: RTL and testbench
=======================================

Name: hex_display_scroller

Overview:
- Parametrised multi-digit seven-segment display driver for the DE-series HEX displays; successor to the two-digit combinational switch-to-HEX decoder.
- Accepts hex nibbles one at a time into a digit shift register, with a registered, glitch-free segment output.
- Adds per-digit blanking, leading-zero suppression, timed rotation and timed blinking of the whole display.

Parameters:
- NUM_DIGITS, 6, number of HEX displays driven (2..8).
- TICK_DIV, 50000000, clock cycles per scroll/blink tick (≥2).
- ACTIVE_LOW, 1, 1 = segment lit when bit is 0 (DE boards); 0 = lit when 1.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- Data  in  4  nibble to load.
- Load  in  1  level input; each rising edge loads Data.
- Clear  in  1  synchronous clear of digit contents.
- Mode  in  2  bit0 = scroll enable, bit1 = blink enable.
- Blank_lz  in  1  1 = suppress leading zeros.
- HEX  out  7*NUM_DIGITS  segments, digit p at HEX[7p+6:7p], bit0 = a … bit6 = g.
- Count  out  $clog2(NUM_DIGITS+1)  number of valid digits, saturating at NUM_DIGITS.

Behaviour:
- Reset, asynchronous and active-high, sets:
  - digits D[] = 0, valid bits V[] = 0, Count = 0;
  - rotate offset R = 0, blink phase Ph = 0, tick counter T = 0;
  - Load_prev = 1, so Load held high through reset does not cause a load;
  - HEX = all segments off (7'h7F per digit when ACTIVE_LOW = 1).
- Load edge: Load & ~Load_prev, sampled each Clock.
  - On an edge: D[i] ← D[i-1] and V[i] ← V[i-1] for i ≥ 1; D[0] ← Data, V[0] ← 1.
  - The old D[NUM_DIGITS-1] is discarded.
  - Count ← min(Count+1, NUM_DIGITS).
- Clear: D, V, Count and R go to 0 on the next edge. Clear has priority over a same-cycle Load edge; that load is lost.
- Tick counter: T counts 0..TICK_DIV-1 and asserts tick on the cycle T == TICK_DIV-1, then wraps to 0.
  - Any change in Mode resets T to 0 on the next edge (no tick that cycle).
- Scroll, Mode[0] = 1: on tick, R ← (R+1) mod NUM_DIGITS.
  - Mode[0] = 0 forces R = 0 on the next edge.
- Blink, Mode[1] = 1: on tick, Ph ← ~Ph.
  - Mode[1] = 0 forces Ph = 0.
- Display mapping: position p shows source digit s = (p − R) mod NUM_DIGITS, i.e. contents rotate toward higher positions.
- A digit is blanked (all off) if any of these holds:
  - V[s] = 0;
  - Blank_lz = 1, s ≠ 0, D[s] = 0, and every valid D[k] with k > s is also 0;
  - Ph = 1 (blanks all digits).
  - Blanking is decided on source index, before rotation.
- Encoding: standard hex 0–F. Active-low values for 0..F: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10, 08, 03, 46, 21, 06, 0E. ACTIVE_LOW = 0 inverts them.
- Latency: Load edge sampled at edge n → D updated at edge n → HEX reflects it at edge n+1. The HEX register is fed from the current-state combinational decode.
- Simultaneous events:
  - Load edge and tick in the same cycle: both take effect; HEX at the next edge uses the new D and new R.
  - Clear and tick in the same cycle: R = 0; Ph still toggles.
- Count saturates at NUM_DIGITS; further loads keep shifting.

Test Plan (NUM_DIGITS = 4, TICK_DIV = 4, ACTIVE_LOW = 1):
- Reset with Load = 1, then release reset with Load still 1 → no load, Count = 0, HEX = 7F7F7F7F; after a Load 0→1 edge with Data = 8 → HEX = 7F7F7F00 two edges later, Count = 1.
- Load 1, 2, 3, 4, 5 in sequence → digits D3..D0 = 2, 3, 4, 5, so HEX = 24301912; Count = 4 (saturated).
- Load 0, 0, 7, Blank_lz = 1 → HEX = 7F7F7F78; Blank_lz = 0 → HEX = 7F404078.
- Contents A, B, C, D (D3..D0), Mode = 01 → after 4 cycles HEX = 03462108; after 16 cycles the original order 08034621 returns.
- Mode = 10 → HEX alternates all-off / contents every 4 cycles; Mode back to 00 → contents shown, T restarts at 0.
- Load edge and Clear in the same cycle → Count = 0, all blank. Assert Reset mid-scroll → HEX immediately all off, R = 0.

Source files
------------

// File: rtl/hex_display_scroller_if.sv
// Request/display bundle for hex_display_scroller: nibble loading, mode controls
// and the registered segment/count outputs.
interface hex_display_scroller_if #(
    parameter int NUM_DIGITS = 6
);
    localparam int CW = $clog2(NUM_DIGITS + 1);

    logic [3:0]              data;
    logic                    load;
    logic                    clear;
    logic [1:0]              mode;
    logic                    blank_lz;
    logic [7*NUM_DIGITS-1:0] hex;
    logic [CW-1:0]           count;

    modport master (
        output data, load, clear, mode, blank_lz,
        input  hex, count
    );

    modport slave (
        input  data, load, clear, mode, blank_lz,
        output hex, count
    );
endinterface

// File: rtl/hex_display_scroller.sv
// Multi-digit seven-segment driver: nibble shift register with blanking,
// leading-zero suppression, timed rotation and blinking; registered segment output.
module hex_display_scroller #(
    parameter int NUM_DIGITS = 6,
    parameter int TICK_DIV   = 50000000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input logic                    clk,
    input logic                    rst,
    hex_display_scroller_if.slave  bus
);
    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RW = $clog2(NUM_DIGITS);
    localparam int SW = RW + 1;

    logic [3:0]              dig [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   vld;
    logic [CW-1:0]           cnt;
    logic [RW-1:0]           rot;
    logic                    ph;
    logic [TW-1:0]           tcnt;
    logic                    load_prev;
    logic [1:0]              mode_prev;
    logic [7*NUM_DIGITS-1:0] hex_q;
    logic [7*NUM_DIGITS-1:0] hex_d;

    logic                    load_edge;
    logic                    mode_chg;
    logic                    tick;

    logic [NUM_DIGITS-1:0]   blank_src;
    logic                    zero_hi;
    logic [SW-1:0]           sum;
    logic [RW-1:0]           src;
    logic                    blank;
    logic [6:0]              seg;

    assign load_edge = bus.load & ~load_prev;
    assign mode_chg  = (bus.mode != mode_prev);
    assign tick      = ~mode_chg & (tcnt == TW'(TICK_DIV - 1));

    assign bus.hex   = hex_q;
    assign bus.count = cnt;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        g = 7'h7F;
        case (d)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            4'hF: g = 7'h0E;
        endcase
        return g;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) dig[i] <= '0;
            vld <= '0;
            cnt <= '0;
        end else if (bus.clear) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) dig[i] <= '0;
            vld <= '0;
            cnt <= '0;
        end else if (load_edge) begin
            for (int unsigned i = 1; i < NUM_DIGITS; i++) dig[i] <= dig[i-1];
            dig[0] <= bus.data;
            vld    <= {vld[NUM_DIGITS-2:0], 1'b1};
            if (cnt != CW'(NUM_DIGITS)) cnt <= cnt + 1'b1;
        end
    end

    // Load_prev resets high so a Load held through reset is not seen as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt      <= '0;
            rot       <= '0;
            ph        <= 1'b0;
            load_prev <= 1'b1;
            mode_prev <= '0;
        end else begin
            load_prev <= bus.load;
            mode_prev <= bus.mode;

            if (mode_chg || tick) tcnt <= '0;
            else                  tcnt <= tcnt + 1'b1;

            if (bus.clear || !bus.mode[0])  rot <= '0;
            else if (tick)                  rot <= (rot == RW'(NUM_DIGITS - 1)) ? '0 : rot + 1'b1;

            if (!bus.mode[1]) ph <= 1'b0;
            else if (tick)    ph <= ~ph;
        end
    end

    // Blanking is evaluated per source digit, then positions pick their source by rotation.
    always_comb begin
        hex_d     = '0;
        blank_src = '0;
        zero_hi   = 1'b0;
        sum       = '0;
        src       = '0;
        blank     = 1'b0;
        seg       = '0;

        for (int unsigned s = 0; s < NUM_DIGITS; s++) begin
            zero_hi = 1'b1;
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                if (k > s && vld[k] && dig[k] != 4'h0) zero_hi = 1'b0;
            end
            blank_src[s] = bus.blank_lz && (s != 0) && (dig[s] == 4'h0) && zero_hi;
        end

        for (int unsigned p = 0; p < NUM_DIGITS; p++) begin
            sum = SW'(p + NUM_DIGITS) - SW'(rot);
            if (sum >= SW'(NUM_DIGITS)) sum = sum - SW'(NUM_DIGITS);
            src   = sum[RW-1:0];
            blank = !vld[src] || ph || blank_src[src];
            seg   = blank ? 7'h7F : glyph(dig[src]);
            hex_d[7*p +: 7] = ACTIVE_LOW ? seg : ~seg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hex_q <= ACTIVE_LOW ? '1 : '0;
        else     hex_q <= hex_d;
    end
endmodule

// File: tb/tb_hex_display_scroller.sv
// Scoreboard bench for hex_display_scroller: a digit-list reference model predicts
// every registered output; a negedge monitor compares, plus directed display checks.
module tb_hex_display_scroller;
    localparam int N  = 4;
    localparam int TD = 4;
    localparam logic [6:0] GLY [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    localparam logic [27:0] ALL_OFF = 28'hFFFFFFF;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    hex_display_scroller_if #(.NUM_DIGITS(N)) bus ();

    hex_display_scroller #(
        .NUM_DIGITS(N),
        .TICK_DIV  (TD),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [27:0] pack(input logic [6:0] a3, input logic [6:0] a2,
                                         input logic [6:0] a1, input logic [6:0] a0);
        return {a3, a2, a1, a0};
    endfunction

    // Reference model: md[0] is the newest digit, mvalid how many are loaded.
    int          md [N];
    int          mvalid, mrot, mph, mt;
    logic        mprev_load;
    logic [1:0]  mprev_mode;
    logic [27:0] qh [$];
    int          qc [$];

    function automatic logic [27:0] render(input logic blz);
        logic [27:0] r;
        int s;
        bit b, hz;
        r = '0;
        for (int p = 0; p < N; p++) begin
            s = (p - mrot + N) % N;
            b = (s >= mvalid) || (mph != 0);
            if (!b && blz && s != 0 && md[s] == 0) begin
                hz = 1;
                for (int k = s + 1; k < mvalid; k++) if (md[k] != 0) hz = 0;
                b = hz;
            end
            r[7*p +: 7] = b ? 7'h7F : GLY[md[s]];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        logic [27:0] eh;
        bit ledge, mchg, tk;
        if (rst) begin
            for (int i = 0; i < N; i++) md[i] = 0;
            mvalid = 0; mrot = 0; mph = 0; mt = 0;
            mprev_load = 1'b1; mprev_mode = 2'b00;
            qh.push_back(ALL_OFF);
            qc.push_back(0);
        end else begin
            eh = render(bus.blank_lz);
            ledge = bus.load && !mprev_load;
            mprev_load = bus.load;
            mchg = (bus.mode != mprev_mode);
            mprev_mode = bus.mode;
            tk = !mchg && (mt == TD - 1);
            mt = (mchg || tk) ? 0 : mt + 1;
            if (bus.clear) begin
                for (int i = 0; i < N; i++) md[i] = 0;
                mvalid = 0;
            end else if (ledge) begin
                for (int i = N - 1; i > 0; i--) md[i] = md[i-1];
                md[0] = int'(bus.data);
                mvalid = (mvalid < N) ? mvalid + 1 : N;
            end
            if (bus.clear || !bus.mode[0]) mrot = 0;
            else if (tk)                   mrot = (mrot + 1) % N;
            if (!bus.mode[1]) mph = 0;
            else if (tk)      mph = 1 - mph;
            qh.push_back(eh);
            qc.push_back(mvalid);
        end
    end

    always @(negedge clk) begin
        logic [27:0] eh;
        int ec;
        if (qh.size() > 0) begin
            eh = qh.pop_front();
            ec = qc.pop_front();
            chk("sb_hex", 32'(bus.hex), 32'(eh));
            chk("sb_count", 32'(bus.count), 32'(ec));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_nib(input logic [3:0] d);
        @(negedge clk);
        bus.data = d;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        bus.load     = 1'b1;
        bus.data     = 4'h0;
        bus.clear    = 1'b0;
        bus.mode     = 2'b00;
        bus.blank_lz = 1'b0;

        // Load held high across reset release must not register.
        cyc(3);
        rst = 1'b0;
        cyc(3);
        chk("rst_hex", 32'(bus.hex), 32'(ALL_OFF));
        chk("rst_count", 32'(bus.count), 32'd0);
        bus.load = 1'b0;
        cyc(1);
        bus.data = 4'h8;
        bus.load = 1'b1;
        cyc(1);
        bus.load = 1'b0;
        cyc(1);
        chk("first_load_hex", 32'(bus.hex), 32'(pack(7'h7F, 7'h7F, 7'h7F, 7'h00)));
        chk("first_load_count", 32'(bus.count), 32'd1);

        do_clear();
        for (int i = 1; i <= 5; i++) load_nib(4'(i));
        cyc(1);
        chk("sat_hex", 32'(bus.hex), 32'(pack(7'h24, 7'h30, 7'h19, 7'h12)));
        chk("sat_count", 32'(bus.count), 32'd4);

        do_clear();
        bus.blank_lz = 1'b1;
        load_nib(4'h0);
        load_nib(4'h0);
        load_nib(4'h7);
        cyc(1);
        chk("lz_on_hex", 32'(bus.hex), 32'(pack(7'h7F, 7'h7F, 7'h7F, 7'h78)));
        bus.blank_lz = 1'b0;
        cyc(1);
        chk("lz_off_hex", 32'(bus.hex), 32'(pack(7'h7F, 7'h40, 7'h40, 7'h78)));

        do_clear();
        load_nib(4'hA);
        load_nib(4'hB);
        load_nib(4'hC);
        load_nib(4'hD);
        cyc(1);
        chk("abcd_hex", 32'(bus.hex), 32'(pack(7'h08, 7'h03, 7'h46, 7'h21)));
        bus.mode = 2'b01;
        cyc(6);
        chk("scroll1_hex", 32'(bus.hex), 32'(pack(7'h03, 7'h46, 7'h21, 7'h08)));
        cyc(12);
        chk("scroll_wrap_hex", 32'(bus.hex), 32'(pack(7'h08, 7'h03, 7'h46, 7'h21)));
        bus.mode = 2'b00;
        cyc(3);

        bus.mode = 2'b10;
        cyc(6);
        chk("blink_off_hex", 32'(bus.hex), 32'(ALL_OFF));
        cyc(4);
        chk("blink_on_hex", 32'(bus.hex), 32'(pack(7'h08, 7'h03, 7'h46, 7'h21)));
        bus.mode = 2'b00;
        cyc(8);

        // Clear wins over a simultaneous load edge.
        bus.data  = 4'h5;
        bus.load  = 1'b1;
        bus.clear = 1'b1;
        cyc(1);
        bus.load  = 1'b0;
        bus.clear = 1'b0;
        cyc(1);
        chk("clr_load_count", 32'(bus.count), 32'd0);
        chk("clr_load_hex", 32'(bus.hex), 32'(ALL_OFF));

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            bus.data     = 4'($urandom);
            bus.load     = 1'($urandom_range(0, 1));
            bus.clear    = ($urandom_range(0, 31) == 0);
            bus.blank_lz = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) bus.mode = 2'($urandom);
        end
        @(negedge clk);
        bus.clear = 1'b0;
        bus.load  = 1'b0;
        bus.mode  = 2'b00;

        load_nib(4'h1);
        load_nib(4'h2);
        load_nib(4'h3);
        bus.mode = 2'b01;
        cyc(7);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_hex", 32'(bus.hex), 32'(ALL_OFF));
        chk("async_rst_count", 32'(bus.count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        load_nib(4'h6);
        load_nib(4'h9);
        cyc(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
